// File: rtl/iob_bus_arbiter.sv
// Two-requester arbiter sharing one IOb native memory port, one transaction in flight.
// Define IOB_BUS_ARBITER_RR_EN for round-robin ties; default gives the data requester priority.
module iob_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  i_avalid_i,
    input  logic [ADDR_W-1:0]     i_addr_i,
    input  logic [DATA_W-1:0]     i_wdata_i,
    input  logic [DATA_W/8-1:0]   i_wstrb_i,
    output logic [DATA_W-1:0]     i_rdata_o,
    output logic                  i_rvalid_o,
    output logic                  i_ready_o,

    input  logic                  d_avalid_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    input  logic [DATA_W/8-1:0]   d_wstrb_i,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  d_rvalid_o,
    output logic                  d_ready_o,

    output logic                  m_avalid_o,
    output logic [ADDR_W-1:0]     m_addr_o,
    output logic [DATA_W-1:0]     m_wdata_o,
    output logic [DATA_W/8-1:0]   m_wstrb_o,
    input  logic [DATA_W-1:0]     m_rdata_i,
    input  logic                  m_rvalid_i,
    input  logic                  m_ready_i,

    output logic                  busy_o
);

    typedef enum logic [1:0] {StIdle, StLocked, StWaitRd} state_e;

    state_e state_q, state_d, state_cur;
    logic   owner_q, owner_d;
    logic   tie_winner;
    logic   winner;
    logic   sel;
    logic   req_valid;
    logic   accepted;
    logic   is_write;

`ifdef IOB_BUS_ARBITER_RR_EN
    // Pointer holds the requester preferred on the next tie (0 = instruction).
    logic rr_q, rr_d;

    assign tie_winner = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (accepted) begin
            rr_d = ~sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign tie_winner = 1'b1;
`endif

    // Outputs see IDLE while reset is held so nothing leaks during the reset cycle.
    always_comb begin
        state_cur = rst_i ? StIdle : state_q;
        winner    = (i_avalid_i && d_avalid_i) ? tie_winner : d_avalid_i;
        sel       = (state_cur == StIdle) ? winner : owner_q;
        req_valid = 1'b0;
        case (state_cur)
            StIdle:   req_valid = i_avalid_i | d_avalid_i;
            StLocked: req_valid = owner_q ? d_avalid_i : i_avalid_i;
            default:  req_valid = 1'b0;
        endcase
    end

    assign m_avalid_o = req_valid;
    assign m_addr_o   = sel ? d_addr_i  : i_addr_i;
    assign m_wdata_o  = sel ? d_wdata_i : i_wdata_i;
    assign m_wstrb_o  = sel ? d_wstrb_i : i_wstrb_i;

    assign accepted = req_valid & m_ready_i;
    assign is_write = |m_wstrb_o;

    assign i_ready_o = req_valid & ~sel & m_ready_i;
    assign d_ready_o = req_valid &  sel & m_ready_i;

    assign i_rdata_o  = m_rdata_i;
    assign d_rdata_o  = m_rdata_i;
    assign i_rvalid_o = (state_cur == StWaitRd) & ~owner_q & m_rvalid_i;
    assign d_rvalid_o = (state_cur == StWaitRd) &  owner_q & m_rvalid_i;

    assign busy_o = (state_cur != StIdle);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    owner_d = sel;
                    if (!accepted) begin
                        state_d = StLocked;
                    end else if (!is_write) begin
                        state_d = StWaitRd;
                    end
                end
            end
            StLocked: begin
                if (!req_valid) begin
                    state_d = StIdle;
                end else if (accepted) begin
                    state_d = is_write ? StIdle : StWaitRd;
                end
            end
            StWaitRd: begin
                if (m_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: doc/iob_bus_arbiter.md
IOB_BUS_ARBITER -- requirements
Module: iob_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; WSTRB_W = DATA_W/8.
REQ-003 The block SHALL have these ports, one per line:
- clk_i  in  1  sole clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- i_avalid_i / i_addr_i / i_wdata_i / i_wstrb_i  in  1/ADDR_W/DATA_W/WSTRB_W  instruction-requester request
- i_rdata_o / i_rvalid_o / i_ready_o  out  DATA_W/1/1  instruction-requester response
- d_avalid_i / d_addr_i / d_wdata_i / d_wstrb_i  in  1/ADDR_W/DATA_W/WSTRB_W  data-requester request
- d_rdata_o / d_rvalid_o / d_ready_o  out  DATA_W/1/1  data-requester response
- m_avalid_o / m_addr_o / m_wdata_o / m_wstrb_o  out  1/ADDR_W/DATA_W/WSTRB_W  shared memory request
- m_rdata_i / m_rvalid_i / m_ready_i  in  DATA_W/1/1  shared memory response
- busy_o  out  1  high when state is not IDLE

Function
REQ-004 The block SHALL share one IOb native memory port between two requesters, with at most one transaction outstanding.
REQ-005 A request SHALL be accepted in the cycle m_avalid_o & m_ready_i; a write (|wstrb) completes at acceptance; a read completes on the first m_rvalid_i after acceptance.
REQ-006 The FSM SHALL have states IDLE, LOCKED and WAIT_RD, plus a 1-bit owner register (0 = instruction, 1 = data).
REQ-007 In IDLE, the winner SHALL be selected combinationally from the asserted avalids; m_* request outputs SHALL mux the winner's request, and the winner's ready_o SHALL equal m_ready_i.
REQ-008 IDLE transitions: winner accepted as read -> WAIT_RD with owner = winner; winner accepted as write -> IDLE; winner not accepted -> LOCKED with owner = winner.
REQ-009 In LOCKED, m_* SHALL carry only the owner's request regardless of the other avalid; owner accepted as read -> WAIT_RD; as write -> IDLE; owner avalid deasserted -> IDLE.
REQ-010 In WAIT_RD, m_avalid_o and both ready_o SHALL be 0; m_rvalid_i SHALL route to the owner's rvalid_o and -> IDLE.
REQ-011 m_rdata_i SHALL drive both rdata_o; rvalid_o of the non-owner SHALL be 0 at all times.
REQ-012 The non-selected requester's ready_o SHALL be 0 in every state.
REQ-013 m_avalid_o SHALL be 0 when no requester is asserting avalid, and in WAIT_RD.
REQ-014 After a read completes, the next request SHALL NOT be issued before the following cycle (minimum one idle cycle after rvalid).
REQ-015 A simultaneous acceptance and m_rvalid_i cannot occur; any m_rvalid_i received in IDLE or LOCKED SHALL be ignored.

Reset
REQ-016 On rst_i high at a clock edge, state SHALL become IDLE, owner 0, and the round-robin pointer 0 (instruction requester preferred next).
REQ-017 During and after reset, m_avalid_o, all ready_o, all rvalid_o and busy_o SHALL be 0 until a requester asserts avalid.
REQ-018 Reset mid-transaction SHALL abandon the outstanding read; a late m_rvalid_i SHALL be ignored in IDLE.

Configuration
REQ-019 Macro IOB_BUS_ARBITER_RR_EN SHALL select the arbitration policy.
REQ-020 With IOB_BUS_ARBITER_RR_EN defined, on a tie in IDLE the requester not served last SHALL win; the pointer SHALL update at each acceptance.
REQ-021 Without IOB_BUS_ARBITER_RR_EN, the data requester SHALL always win ties, and no pointer register SHALL exist.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- i-read addr 0x100, ready=1, rvalid 2 cycles later with rdata 0xDEADBEEF -> i_rvalid_o=1 with i_rdata_o=0xDEADBEEF, d_rvalid_o=0, busy_o high 2 cycles.
- d-write addr 0x200, wstrb 0xF, ready=1 -> d_ready_o=1 in the same cycle, state stays IDLE, no rvalid expected.
- Both avalid every cycle, reads, 4 transactions -> without macro: d,d,d,d; with RR_EN: i,d,i,d.
- i avalid with ready=0 for 3 cycles, d avalid from cycle 2 -> m_addr_o stays at the i address until acceptance (LOCKED); d is served next.
- rst_i asserted in WAIT_RD, then m_rvalid_i pulses -> both rvalid_o stay 0 and state is IDLE.
